// File: rtl/int_to_float_pipe_pkg.sv
// rtl/int_to_float_pipe_pkg.sv - shared fp32 field constants, types and helpers
//
// Shared by the int-to-float converter and the fp add/subtract datapath.
// Provides the single-precision field layout, the exponent bias, the
// exponent of a value whose leading one sits in bit 31 of a 32-bit word,
// the packed fp32 field struct and a small packing helper.
package int_to_float_pipe_pkg;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_FRAC_MSB = 22;
  localparam int FP32_EXP_W    = FP32_EXP_MSB - FP32_EXP_LSB + 1;
  localparam int FP32_FRAC_W   = FP32_FRAC_MSB + 1;

  localparam int FP32_EXP_BIAS = 127;

  // Biased exponent of 2^31: a normalised 32-bit magnitude with lzc leading
  // zeros has biased exponent FP32_EXP_INT_MAX - lzc.
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_INT_MAX = FP32_EXP_W'(FP32_EXP_BIAS + 31);

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exponent;
    logic [FP32_FRAC_W-1:0] fraction;
  } fp32_t;

  function automatic fp32_t fp32_pack(
    input logic                   sign,
    input logic [FP32_EXP_W-1:0]  exponent,
    input logic [FP32_FRAC_W-1:0] fraction
  );
    fp32_t r;
    r.sign     = sign;
    r.exponent = exponent;
    r.fraction = fraction;
    return r;
  endfunction

endpackage

// File: rtl/int_to_float_pipe_if.sv
// rtl/int_to_float_pipe_if.sv - handshake bundle for the int-to-float converter
//
// Groups the input stream (in_valid/in_ready/in_data) and the output stream
// (out_valid/out_ready/result/inexact).
//   master : producer of integers / consumer of results (testbench side)
//   slave  : the converter itself
interface int_to_float_pipe_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        inexact;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  inexact
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output inexact
  );

endinterface

// File: rtl/int_to_float_pipe_lzc32.sv
// rtl/int_to_float_pipe_lzc32.sv - combinational 32-bit leading-zero counter
//
// Ports:
//   a     in  32  value to scan
//   count out 6   number of leading zeros of a, 0..31; 32 when a is zero
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  count
);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) begin
        count = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// rtl/int_to_float_pipe.sv - 3-stage int32 to IEEE-754 single converter, RNE
//
// Ports:
//   clk    in   clock, all state on the rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of int_to_float_pipe_if:
//            in_valid/in_ready/in_data    signed int32 input stream
//            out_valid/out_ready/result   fp32 result stream
//            inexact                      result was rounded (with out_valid)
//
// S1 takes sign and magnitude, S2 normalises with the leading-zero count,
// S3 rounds to nearest even. Each stage advances when it is empty or its
// successor advances, so in_ready is combinational from out_ready.
module int_to_float_pipe
  import int_to_float_pipe_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  int_to_float_pipe_if.slave bus
);

  logic adv1;
  logic adv2;
  logic adv3;

  // Stage 1 state
  logic        v1_q,    v1_d;
  logic        sign1_q, sign1_d;
  logic [31:0] mag1_q,  mag1_d;
  logic        zero1_q, zero1_d;

  // Stage 2 state
  logic        v2_q,    v2_d;
  logic        sign2_q, sign2_d;
  logic        zero2_q, zero2_d;
  logic [31:0] norm2_q, norm2_d;
  logic [7:0]  exp2_q,  exp2_d;

  // Stage 3 state
  logic        v3_q,      v3_d;
  fp32_t       result_q,  result_d;
  logic        inexact_q, inexact_d;

  // Stage 2 / stage 3 combinational terms
  logic [5:0]  lzc;
  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] mant_sum;
  logic        carry;
  logic [7:0]  exp_r;
  logic [22:0] frac_r;

  always_comb begin
    adv3 = !v3_q || bus.out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3_q;
  assign bus.result    = result_q;
  assign bus.inexact   = inexact_q;

  // S1: sign / magnitude split. Negating -2^31 wraps to 0x80000000, which
  // read as unsigned is exactly the magnitude we want.
  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    mag1_d  = mag1_q;
    zero1_d = zero1_q;
    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        sign1_d = bus.in_data[FP32_SIGN_BIT];
        mag1_d  = bus.in_data[FP32_SIGN_BIT] ? (32'd0 - bus.in_data) : bus.in_data;
        zero1_d = (bus.in_data == 32'd0);
      end
    end
  end

  lzc32 u_lzc (
    .a     (mag1_q),
    .count (lzc)
  );

  // S2: normalise so the leading one lands in bit 31. For a zero magnitude
  // lzc is 32, the shift yields 0 and the exponent is don't-care because S3
  // substitutes a signed zero.
  always_comb begin
    v2_d    = v2_q;
    sign2_d = sign2_q;
    zero2_d = zero2_q;
    norm2_d = norm2_q;
    exp2_d  = exp2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        zero2_d = zero1_q;
        norm2_d = mag1_q << lzc;
        exp2_d  = FP32_EXP_INT_MAX - {2'b00, lzc};
      end
    end
  end

  // S3: round to nearest even on the 24-bit significand norm[31:8].
  // A carry out of the significand means it was all ones; the result is
  // then 1.0 x 2^(exp+1), and exp+1 never exceeds 159.
  always_comb begin
    lsb      = norm2_q[8];
    guard    = norm2_q[7];
    sticky   = |norm2_q[6:0];
    round_up = guard & (sticky | lsb);
    mant_sum = {1'b0, norm2_q[31:8]} + {24'd0, round_up};
    carry    = mant_sum[24];
    frac_r   = carry ? mant_sum[23:1] : mant_sum[22:0];
    exp_r    = exp2_q + {7'd0, carry};

    v3_d      = v3_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        if (zero2_q) begin
          result_d  = fp32_pack(sign2_q, 8'd0, 23'd0);
          inexact_d = 1'b0;
        end else begin
          result_d  = fp32_pack(sign2_q, exp_r, frac_r);
          inexact_d = guard | sticky;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      mag1_q    <= 32'd0;
      zero1_q   <= 1'b0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      zero2_q   <= 1'b0;
      norm2_q   <= 32'd0;
      exp2_q    <= 8'd0;
      v3_q      <= 1'b0;
      result_q  <= '0;
      inexact_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      sign1_q   <= sign1_d;
      mag1_q    <= mag1_d;
      zero1_q   <= zero1_d;
      v2_q      <= v2_d;
      sign2_q   <= sign2_d;
      zero2_q   <= zero2_d;
      norm2_q   <= norm2_d;
      exp2_q    <= exp2_d;
      v3_q      <= v3_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end

endmodule
